parallel_descrambler: RTL and testbench



---
 rtl/parallel_descrambler_pkg.sv | 13 +
 rtl/parallel_descrambler_core.sv | 16 +
 rtl/parallel_descrambler.sv | 55 +++++
 tb/tb_parallel_descrambler.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/parallel_descrambler_pkg.sv
// parallel_descrambler_pkg: shared PCS widths, scrambler taps and sync-header codes
package parallel_descrambler_pkg;
  localparam int LEN_CODED_BLOCK = 66;
  localparam int LEN_SCRAMBLER = 58;
  localparam int LEN_PAYLOAD = 64;
  localparam int SCR_TAP_A = 39;
  localparam int SCR_TAP_B = 58;
  localparam logic [1:0] SH_DATA = 2'b01;
  localparam logic [1:0] SH_CTRL = 2'b10;
  function automatic logic header_bad(input logic [1:0] h);
    return h != SH_DATA && h != SH_CTRL;
  endfunction
endpackage

// File: rtl/parallel_descrambler_core.sv
// descrambler_core: combinational 1 + x^39 + x^58 self-synchronizing descramble of one payload
module descrambler_core
  import parallel_descrambler_pkg::*;
(
  input  logic [LEN_SCRAMBLER-1:0] state,
  input  logic [LEN_PAYLOAD-1:0]   payload,
  output logic [LEN_PAYLOAD-1:0]   d,
  output logic [LEN_SCRAMBLER-1:0] next_state
);
  logic [LEN_SCRAMBLER+LEN_PAYLOAD-1:0] e;
  assign e = {state, payload};
  for (genvar i = 0; i < LEN_PAYLOAD; i++) begin : g_tap
    assign d[i] = e[i] ^ e[i+SCR_TAP_A] ^ e[i+SCR_TAP_B];
  end
  assign next_state = payload[LEN_SCRAMBLER-1:0];
endmodule

// File: rtl/parallel_descrambler.sv
// parallel_descrambler: registered 66b block descrambler with bypass, seeded flag and header-error counter
module parallel_descrambler
  import parallel_descrambler_pkg::*;
#(
  parameter int                       LEN_SCRAMBLER   = 58,
  parameter int                       LEN_CODED_BLOCK = 66,
  parameter logic [LEN_SCRAMBLER-1:0] SEED            = '0,
  parameter int                       NB_ERR_CNT      = 8
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_enable,
  input  logic                       i_bypass,
  input  logic [LEN_CODED_BLOCK-1:0] i_data,
  output logic [LEN_CODED_BLOCK-1:0] o_data,
  output logic                       o_valid,
  output logic                       o_seeded,
  output logic                       o_header_error,
  output logic [NB_ERR_CNT-1:0]      o_error_count
);
  logic [LEN_SCRAMBLER-1:0] state;
  logic [LEN_SCRAMBLER-1:0] next_state;
  logic [LEN_CODED_BLOCK-3:0] d;
  logic [1:0] hdr;
  logic bad;
  assign hdr = i_data[LEN_CODED_BLOCK-1 -: 2];
  assign bad = header_bad(hdr);
  descrambler_core u_core (
    .state      (state),
    .payload    (i_data[LEN_CODED_BLOCK-3:0]),
    .d          (d),
    .next_state (next_state)
  );
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_data         <= '0;
      o_valid        <= 1'b0;
      o_seeded       <= 1'b0;
      o_header_error <= 1'b0;
      o_error_count  <= '0;
      state          <= SEED;
    end else begin
      o_valid        <= i_enable;
      o_header_error <= i_enable && bad;
      if (i_enable) begin
        o_data <= i_bypass ? i_data : {hdr, d};
        if (!i_bypass) begin
          state    <= next_state;
          o_seeded <= 1'b1;
        end
        if (bad && !(&o_error_count)) o_error_count <= o_error_count + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_parallel_descrambler.sv
// tb_parallel_descrambler: scoreboard bench with a serial scrambler model feeding two descrambler instances
module tb_parallel_descrambler;
  typedef struct {
    logic [65:0] d;
    logic        herr;
    logic        first2;
  } exp_t;
  logic i_clock = 1'b0;
  logic i_reset = 1'b0;
  logic i_enable = 1'b0;
  logic i_bypass = 1'b0;
  logic [65:0] i_data = '0;
  logic [65:0] o_data, o_data2;
  logic o_valid, o_valid2, o_seeded, o_seeded2, o_herr, o_herr2;
  logic [7:0] o_cnt;
  logic [1:0] o_cnt2;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  logic [57:0] scr_state = '0;
  logic seeded_exp = 1'b0;
  logic first_pending = 1'b1;
  logic [65:0] last_exp = '0;
  logic [7:0] cnt_exp = '0;
  logic [1:0] cnt2_exp = '0;
  parallel_descrambler u_dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_enable(i_enable), .i_bypass(i_bypass),
    .i_data(i_data), .o_data(o_data), .o_valid(o_valid), .o_seeded(o_seeded),
    .o_header_error(o_herr), .o_error_count(o_cnt)
  );
  parallel_descrambler #(.SEED({58{1'b1}}), .NB_ERR_CNT(2)) u_dut2 (
    .i_clock(i_clock), .i_reset(i_reset), .i_enable(i_enable), .i_bypass(i_bypass),
    .i_data(i_data), .o_data(o_data2), .o_valid(o_valid2), .o_seeded(o_seeded2),
    .o_header_error(o_herr2), .o_error_count(o_cnt2)
  );
  always #5 i_clock = ~i_clock;
  task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic chk_ne(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    checks++;
    assert (obs !== exp) else begin
      errors++;
      $error("FAIL %s observed %h expected anything but %h", tag, obs, exp);
    end
  endtask
  function automatic logic [63:0] scramble(input logic [63:0] plain);
    logic [121:0] ee;
    ee = {scr_state, 64'h0};
    for (int k = 63; k >= 0; k--) ee[k] = plain[k] ^ ee[k+39] ^ ee[k+58];
    return ee[63:0];
  endfunction
  task automatic drive(input logic en, input logic byp, input logic [65:0] din, input logic [65:0] exp);
    exp_t x;
    logic bad;
    bad = din[65:64] == 2'b00 || din[65:64] == 2'b11;
    i_enable = en;
    i_bypass = byp;
    i_data = din;
    if (en) begin
      x.d = exp;
      x.herr = bad;
      x.first2 = !byp && first_pending;
      sb.push_back(x);
      if (!byp) begin
        scr_state = din[57:0];
        seeded_exp = 1'b1;
        first_pending = 1'b0;
      end
      if (bad) begin
        cnt_exp = cnt_exp == 8'hFF ? cnt_exp : cnt_exp + 8'd1;
        cnt2_exp = cnt2_exp == 2'b11 ? cnt2_exp : cnt2_exp + 2'd1;
      end
    end
    @(posedge i_clock);
    #1;
    if (en) begin
      x = sb.pop_front();
      last_exp = x.d;
      chk("data", o_data, x.d);
      if (x.first2) chk_ne("data2_first", o_data2, x.d);
      else chk("data2", o_data2, x.d);
      chk("valid", {65'b0, o_valid}, 66'd1);
      chk("herr", {65'b0, o_herr}, {65'b0, x.herr});
      chk("herr2", {65'b0, o_herr2}, {65'b0, x.herr});
    end else begin
      chk("hold_data", o_data, last_exp);
      chk("idle_valid", {65'b0, o_valid}, 66'd0);
      chk("idle_herr", {65'b0, o_herr}, 66'd0);
    end
    chk("seeded", {65'b0, o_seeded}, {65'b0, seeded_exp});
    chk("seeded2", {65'b0, o_seeded2}, {65'b0, seeded_exp});
    chk("cnt", {58'b0, o_cnt}, {58'b0, cnt_exp});
    chk("cnt2", {64'b0, o_cnt2}, {64'b0, cnt2_exp});
  endtask
  task automatic blk(input logic byp, input logic [1:0] hdr);
    logic [63:0] plain;
    logic [65:0] din;
    plain = {$urandom, $urandom};
    din = byp ? {hdr, plain} : {hdr, scramble(plain)};
    drive(1'b1, byp, din, byp ? din : {hdr, plain});
  endtask
  task automatic do_reset();
    i_reset = 1'b1;
    i_enable = 1'b0;
    i_bypass = 1'b0;
    @(posedge i_clock);
    #1;
    i_reset = 1'b0;
    scr_state = '0;
    seeded_exp = 1'b0;
    first_pending = 1'b1;
    last_exp = '0;
    cnt_exp = '0;
    cnt2_exp = '0;
    sb.delete();
    chk("rst_data", o_data, 66'd0);
    chk("rst_data2", o_data2, 66'd0);
    chk("rst_valid", {65'b0, o_valid}, 66'd0);
    chk("rst_seeded", {64'b0, o_seeded, o_seeded2}, 66'd0);
    chk("rst_herr", {64'b0, o_herr, o_herr2}, 66'd0);
    chk("rst_cnt", {56'b0, o_cnt, o_cnt2}, 66'd0);
  endtask
  initial begin
    logic [1:0] bad_hdrs [7];
    bad_hdrs = '{2'b00, 2'b11, 2'b01, 2'b10, 2'b00, 2'b11, 2'b00};
    do_reset();
    drive(1'b1, 1'b0, {2'b01, 64'h8000_0000_0000_0000}, {2'b01, 64'h8000_0000_0100_0020});
    for (int n = 0; n < 2000; n++) blk(1'b0, $urandom_range(0, 1) ? 2'b01 : 2'b10);
    for (int n = 0; n < 5; n++) blk(1'b1, 2'b01);
    for (int n = 0; n < 20; n++) blk(1'b0, 2'b10);
    for (int n = 0; n < 7; n++) blk(1'b0, bad_hdrs[n]);
    for (int n = 0; n < 3; n++) drive(1'b0, 1'b0, {$urandom, $urandom, 2'b11}, '0);
    for (int n = 0; n < 4; n++) blk(1'b0, 2'b01);
    do_reset();
    for (int n = 0; n < 10; n++) blk(1'b0, 2'b01);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
